mf_disp_vga_timing: RTL

Display timing generator and pixel-fetch sequencer that sits directly upstream of the frame-buffer/palette read path. It scans a 640x400 VGA raster and issues pixel read requests into a 320x200, 8-bit-indexed frame buffer, with 2x2 pixel doubling. It realigns HSYNC/VSYNC/blanking with the palette RGB returned after a fixed pipeline delay. It also owns the double-buffer select, flipping it only during vertical blanking on request.

---
 rtl/mf_disp_vga_timing_pkg.sv | 33 +++
 rtl/mf_disp_delay_line.sv | 32 +++
 rtl/mf_disp_vga_timing.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/mf_disp_vga_timing_pkg.sv
// Shared raster defaults, control-word layout and sync helper for the
// VGA timing generator and its delay line.
package mf_disp_vga_timing_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 400;
    localparam int DEF_V_FP     = 12;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 35;
    localparam bit DEF_HSYNC_POL = 1'b0;
    localparam bit DEF_VSYNC_POL = 1'b1;
    localparam int DEF_FB_WIDTH = 320;
    localparam int DEF_PIPE_DLY = 4;

    localparam int ADDR_W    = 16;
    localparam int RGB_IN_W  = 6;
    localparam int RGB_OUT_W = 4;

    typedef struct packed {
        logic de;
        logic hs;
        logic vs;
    } disp_ctl_t;

    // Maps an in-window sync flag onto the configured output polarity.
    function automatic logic sync_level(input logic in_window, input logic pol);
        return in_window ? pol : ~pol;
    endfunction

endpackage

// File: rtl/mf_disp_delay_line.sv
// Parametric shift register with a configurable reset word; carries the
// de/hs/vs control word alongside the palette read latency.
module mf_disp_delay_line #(
    parameter int               WIDTH   = 1,
    parameter int               DEPTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage [DEPTH];

    // Shift chain; reset loads every stage with the idle word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= RST_VAL;
            end
        end else begin
            stage[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign dout = stage[DEPTH-1];

endmodule

// File: rtl/mf_disp_vga_timing.sv
// VGA raster timing and 2x2-doubled frame-buffer fetch sequencer with
// palette-aligned sync/RGB outputs and vblank-synchronous buffer flip.
module mf_disp_vga_timing
    import mf_disp_vga_timing_pkg::*;
#(
    parameter int H_ACTIVE  = DEF_H_ACTIVE,
    parameter int H_FP      = DEF_H_FP,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BP      = DEF_H_BP,
    parameter int V_ACTIVE  = DEF_V_ACTIVE,
    parameter int V_FP      = DEF_V_FP,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BP      = DEF_V_BP,
    parameter bit HSYNC_POL = DEF_HSYNC_POL,
    parameter bit VSYNC_POL = DEF_VSYNC_POL,
    parameter int FB_WIDTH  = DEF_FB_WIDTH,
    parameter int PIPE_DLY  = DEF_PIPE_DLY
) (
    input  logic                 pix_clk,
    input  logic                 reset,
    input  logic                 swap_req,
    input  logic [RGB_IN_W-1:0]  pix_rd_rdata,
    input  logic [RGB_IN_W-1:0]  pix_rd_gdata,
    input  logic [RGB_IN_W-1:0]  pix_rd_bdata,
    output logic                 pix_rd_vld,
    output logic [ADDR_W-1:0]    pix_rd_addr,
    output logic                 pix_fb_active_sel,
    output logic                 swap_done,
    output logic                 frame_start,
    output logic                 vga_hsync,
    output logic                 vga_vsync,
    output logic [RGB_OUT_W-1:0] vga_r,
    output logic [RGB_OUT_W-1:0] vga_g,
    output logic [RGB_OUT_W-1:0] vga_b
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0]     H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0]     H_ACT      = HW'(H_ACTIVE);
    localparam logic [HW-1:0]     HS_BEG     = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0]     HS_END     = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0]     V_LAST     = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0]     V_ACT      = VW'(V_ACTIVE);
    localparam logic [VW-1:0]     V_ACT_LAST = VW'(V_ACTIVE - 1);
    localparam logic [VW-1:0]     VS_BEG     = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0]     VS_END     = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [ADDR_W-1:0] LINE_STEP  = ADDR_W'(FB_WIDTH);

    logic [HW-1:0]     h;
    logic [VW-1:0]     v;
    logic [ADDR_W-1:0] line_base;
    logic              pending;
    logic              active;
    logic              h_end;
    logic              frame_end;
    logic              swap_edge;
    logic              swap_now;
    disp_ctl_t         ctl_raw;
    disp_ctl_t         ctl_dly;
    logic              unused_rgb_lsbs;

    assign h_end     = (h == H_LAST);
    assign frame_end = h_end && (v == V_LAST);
    assign swap_edge = h_end && (v == V_ACT_LAST);
    assign swap_now  = pending || swap_req;
    assign active    = (h < H_ACT) && (v < V_ACT);

    assign ctl_raw.de = active;
    assign ctl_raw.hs = sync_level((h >= HS_BEG) && (h < HS_END), HSYNC_POL);
    assign ctl_raw.vs = sync_level((v >= VS_BEG) && (v < VS_END), VSYNC_POL);

    // The palette only supplies 4 significant bits per colour to the DAC.
    assign unused_rgb_lsbs = ^{pix_rd_rdata[1:0], pix_rd_gdata[1:0], pix_rd_bdata[1:0]};

    // Raster position counters.
    always_ff @(posedge pix_clk or posedge reset) begin
        if (reset) begin
            h <= {HW{1'b0}};
            v <= {VW{1'b0}};
        end else if (h_end) begin
            h <= {HW{1'b0}};
            v <= (v == V_LAST) ? {VW{1'b0}} : v + VW'(1);
        end else begin
            h <= h + HW'(1);
        end
    end

    // Fetch request issue; line_base advances every second active line so
    // each frame-buffer row is scanned twice without a multiplier.
    always_ff @(posedge pix_clk or posedge reset) begin
        if (reset) begin
            pix_rd_vld  <= 1'b0;
            pix_rd_addr <= {ADDR_W{1'b0}};
            line_base   <= {ADDR_W{1'b0}};
            frame_start <= 1'b0;
        end else begin
            pix_rd_vld  <= active;
            frame_start <= frame_end;
            if (active) begin
                pix_rd_addr <= line_base + ADDR_W'(h[HW-1:1]);
            end
            if (h_end) begin
                if (v == V_LAST) begin
                    line_base <= {ADDR_W{1'b0}};
                end else if ((v < V_ACT) && v[0]) begin
                    line_base <= line_base + LINE_STEP;
                end
            end
        end
    end

    // Buffer flip at the end of the last active line; requests coalesce.
    always_ff @(posedge pix_clk or posedge reset) begin
        if (reset) begin
            pending           <= 1'b0;
            pix_fb_active_sel <= 1'b0;
            swap_done         <= 1'b0;
        end else if (swap_edge) begin
            pending   <= 1'b0;
            swap_done <= swap_now;
            if (swap_now) begin
                pix_fb_active_sel <= ~pix_fb_active_sel;
            end
        end else begin
            pending   <= pending | swap_req;
            swap_done <= 1'b0;
        end
    end

    mf_disp_delay_line #(
        .WIDTH   (3),
        .DEPTH   (PIPE_DLY),
        .RST_VAL ({1'b0, ~HSYNC_POL, ~VSYNC_POL})
    ) u_ctl_dly (
        .clk  (pix_clk),
        .rst  (reset),
        .din  (ctl_raw),
        .dout (ctl_dly)
    );

    // Output stage: syncs and gated colour captured on the same edge.
    always_ff @(posedge pix_clk or posedge reset) begin
        if (reset) begin
            vga_hsync <= ~HSYNC_POL;
            vga_vsync <= ~VSYNC_POL;
            vga_r     <= {RGB_OUT_W{1'b0}};
            vga_g     <= {RGB_OUT_W{1'b0}};
            vga_b     <= {RGB_OUT_W{1'b0}};
        end else begin
            vga_hsync <= ctl_dly.hs;
            vga_vsync <= ctl_dly.vs;
            if (ctl_dly.de) begin
                vga_r <= pix_rd_rdata[5:2];
                vga_g <= pix_rd_gdata[5:2];
                vga_b <= pix_rd_bdata[5:2];
            end else begin
                vga_r <= {RGB_OUT_W{1'b0}};
                vga_g <= {RGB_OUT_W{1'b0}};
                vga_b <= {RGB_OUT_W{1'b0}};
            end
        end
    end

endmodule
